time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/clock_pkg.sv | 31 +++
 rtl/edge_detect.sv | 18 +
 rtl/time_set_ctrl.sv | 125 ++++++++++++
 tb/tb_time_set_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared codes for the clock: set-mode states and display select values.
// The display path and the time-set controller both import this package.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_SET_SEC  = 2'd1,
      ST_SET_MIN  = 2'd2,
      ST_SET_HOUR = 2'd3
   } mode_e;

   localparam logic [1:0] SEL_ALL  = 2'd0;
   localparam logic [1:0] SEL_SEC  = 2'd1;
   localparam logic [1:0] SEL_MIN  = 2'd2;
   localparam logic [1:0] SEL_HOUR = 2'd3;

   localparam logic [1:0] HOLD_MAX = 2'd3;
   localparam logic [1:0] HOLD_REP = 2'd2;

   function automatic mode_e next_mode(input mode_e m);
      mode_e n;
      unique case (m)
         ST_NORMAL:   n = ST_SET_HOUR;
         ST_SET_HOUR: n = ST_SET_MIN;
         ST_SET_MIN:  n = ST_SET_SEC;
         default:     n = ST_NORMAL;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector against a registered previous level.
// Reset loads the current level so a held button yields no edge.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic lvl_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk) begin
      prev_q <= lvl_i;
   end

   assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: mode cycling, blink select, increment strobes,
// button auto-repeat and inactivity timeout back to NORMAL.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned TIMEOUT_S = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   output logic [1:0] select_mode,
   output logic [1:0] mode_state,
   output logic       run_en,
   output logic       inc_hour,
   output logic       inc_min,
   output logic       inc_sec
);

   localparam int IW = $clog2(TIMEOUT_S + 1);

   mode_e          state_q, state_d;
   logic           blink_q, blink_d;
   logic [1:0]     hold_q,  hold_d;
   logic [IW-1:0]  idle_q,  idle_d;
   logic [1:0]     sel_q,   sel_d;
   logic           run_q;
   logic [2:0]     inc_q,   inc_d;

   logic mode_rise, inc_rise;
   logic in_set, tmo, enter, rep, fire;

   edge_detect u_mode_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .lvl_i  (btn_mode),
      .rise_o (mode_rise)
   );

   edge_detect u_inc_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .lvl_i  (btn_inc),
      .rise_o (inc_rise)
   );

   always_comb begin
      in_set  = (state_q != ST_NORMAL);
      tmo     = in_set && (idle_q == IW'(TIMEOUT_S));
      enter   = tmo || mode_rise;
      rep     = in_set && btn_inc && tick_2hz && (hold_q >= HOLD_REP);
      // A mode change or timeout suppresses any strobe in the same cycle
      fire    = in_set && !enter && (inc_rise || rep);

      state_d = state_q;
      if (tmo)
         state_d = ST_NORMAL;
      else if (mode_rise)
         state_d = next_mode(state_q);

      blink_d = blink_q;
      hold_d  = hold_q;
      idle_d  = idle_q;
      if (enter || !in_set) begin
         blink_d = 1'b0;
         hold_d  = '0;
         idle_d  = '0;
      end else begin
         if (tick_2hz)
            blink_d = ~blink_q;
         if (!btn_inc || inc_rise)
            hold_d = '0;
         else if (tick_2hz && hold_q != HOLD_MAX)
            hold_d = hold_q + 2'd1;
         if (inc_rise || rep)
            idle_d = '0;
         else if (tick_1hz)
            idle_d = idle_q + IW'(1);
      end

      sel_d = SEL_ALL;
      if (state_d != ST_NORMAL && blink_d)
         sel_d = state_d;

      inc_d = '0;
      if (fire) begin
         unique case (state_q)
            ST_SET_HOUR: inc_d = 3'b100;
            ST_SET_MIN:  inc_d = 3'b010;
            ST_SET_SEC:  inc_d = 3'b001;
            default:     inc_d = 3'b000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_NORMAL;
         blink_q <= 1'b0;
         hold_q  <= '0;
         idle_q  <= '0;
         sel_q   <= SEL_ALL;
         run_q   <= 1'b1;
         inc_q   <= '0;
      end else begin
         state_q <= state_d;
         blink_q <= blink_d;
         hold_q  <= hold_d;
         idle_q  <= idle_d;
         sel_q   <= sel_d;
         run_q   <= (state_d == ST_NORMAL);
         inc_q   <= inc_d;
      end
   end

   assign mode_state  = state_q;
   assign select_mode = sel_q;
   assign run_en      = run_q;
   assign inc_hour    = inc_q[2];
   assign inc_min     = inc_q[1];
   assign inc_sec     = inc_q[0];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a cycle model pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_time_set_ctrl;

   localparam int TMO = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       tick_2hz = 1'b0;
   logic [1:0] select_mode, mode_state;
   logic       run_en, inc_hour, inc_min, inc_sec;

   time_set_ctrl #(.TIMEOUT_S(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_mode    (btn_mode),
      .btn_inc     (btn_inc),
      .tick_1hz    (tick_1hz),
      .tick_2hz    (tick_2hz),
      .select_mode (select_mode),
      .mode_state  (mode_state),
      .run_en      (run_en),
      .inc_hour    (inc_hour),
      .inc_min     (inc_min),
      .inc_sec     (inc_sec)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] sel;
      logic [1:0] st;
      logic       run;
      logic       ih;
      logic       im;
      logic       is;
   } exp_t;

   exp_t q[$];

   int total = 0;
   int bad = 0;
   int cnt_h = 0, cnt_m = 0, cnt_s = 0;

   int m_st = 0, m_blink = 0, m_hold = 0, m_idle = 0;
   bit m_pm = 1'b0, m_pi = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(output exp_t e);
      bit mr, ir, rep, tmo;
      e = '0;
      if (!rst_n) begin
         m_st = 0; m_blink = 0; m_hold = 0; m_idle = 0;
         m_pm = btn_mode; m_pi = btn_inc;
         e.run = 1'b1;
         return;
      end
      mr = btn_mode && !m_pm;
      ir = btn_inc && !m_pi;
      m_pm = btn_mode;
      m_pi = btn_inc;
      tmo = (m_st != 0) && (m_idle == TMO);
      if (tmo || mr) begin
         m_st = tmo ? 0 : (m_st == 0 ? 3 : m_st - 1);
         m_blink = 0; m_hold = 0; m_idle = 0;
      end else if (m_st != 0) begin
         rep = btn_inc && tick_2hz && (m_hold >= 2);
         if (ir || rep) begin
            if (m_st == 3) e.ih = 1'b1;
            if (m_st == 2) e.im = 1'b1;
            if (m_st == 1) e.is = 1'b1;
         end
         if (!btn_inc || ir) m_hold = 0;
         else if (tick_2hz && m_hold < 3) m_hold++;
         if (ir || rep) m_idle = 0;
         else if (tick_1hz) m_idle++;
         if (tick_2hz) m_blink ^= 1;
      end
      e.st  = 2'(m_st);
      e.run = (m_st == 0);
      e.sel = (m_st != 0 && m_blink != 0) ? 2'(m_st) : 2'd0;
   endtask

   task automatic step();
      exp_t e, g;
      model(e);
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         chk("queue_empty", 0, 1);
      end else begin
         g = q.pop_front();
         chk("select_mode", select_mode, g.sel);
         chk("mode_state", mode_state, g.st);
         chk("run_en", run_en, g.run);
         chk("inc_hour", inc_hour, g.ih);
         chk("inc_min", inc_min, g.im);
         chk("inc_sec", inc_sec, g.is);
      end
      cnt_h += inc_hour;
      cnt_m += inc_min;
      cnt_s += inc_sec;
   endtask

   task automatic press_mode();
      btn_mode = 1'b1; step();
      btn_mode = 1'b0; step();
   endtask

   task automatic pulse_2hz();
      tick_2hz = 1'b1; step();
      tick_2hz = 1'b0; step();
   endtask

   int seq_st[4];
   int seq_run[4];

   initial begin
      // reset with mode button held: release must produce no edge
      btn_mode = 1'b1;
      step(); step();
      rst_n = 1'b1;
      step(); step();
      chk("held_at_reset_state", mode_state, 0);
      chk("reset_run_en", run_en, 1);
      btn_mode = 1'b0; step();

      for (int i = 0; i < 4; i++) begin
         btn_mode = 1'b1; step();
         seq_st[i] = mode_state;
         seq_run[i] = run_en;
         btn_mode = 1'b0; step();
      end
      chk("mode_seq0", seq_st[0], 3);
      chk("mode_seq1", seq_st[1], 2);
      chk("mode_seq2", seq_st[2], 1);
      chk("mode_seq3", seq_st[3], 0);
      chk("run_seq", {seq_run[0][0], seq_run[1][0], seq_run[2][0], seq_run[3][0]}, 4'b0001);

      // SET_MIN: three inc pulses
      press_mode(); press_mode();
      chk("in_set_min", mode_state, 2);
      cnt_h = 0; cnt_m = 0; cnt_s = 0;
      for (int i = 0; i < 3; i++) begin
         btn_inc = 1'b1; step();
         btn_inc = 1'b0; step(); step();
      end
      chk("min_strobes", cnt_m, 3);
      chk("min_no_hour_sec", cnt_h + cnt_s, 0);

      // blink in SET_MIN: 2, 0, 2
      tick_2hz = 1'b1; step(); chk("blink1", select_mode, 2);
      tick_2hz = 1'b0; step();
      tick_2hz = 1'b1; step(); chk("blink2", select_mode, 0);
      tick_2hz = 1'b0; step();
      tick_2hz = 1'b1; step(); chk("blink3", select_mode, 2);
      tick_2hz = 1'b0; step();

      // to SET_HOUR, hold inc for 8 half-second ticks
      press_mode(); press_mode(); press_mode();
      chk("in_set_hour", mode_state, 3);
      cnt_h = 0; cnt_m = 0; cnt_s = 0;
      btn_inc = 1'b1; step();
      for (int i = 0; i < 8; i++) pulse_2hz();
      btn_inc = 1'b0; step();
      chk("hold_hour_strobes", cnt_h, 7);
      chk("hold_other_strobes", cnt_m + cnt_s, 0);

      // simultaneous mode and inc edges
      cnt_h = 0; cnt_m = 0; cnt_s = 0;
      btn_mode = 1'b1; btn_inc = 1'b1; step();
      chk("coinc_state", mode_state, 2);
      btn_mode = 1'b0; btn_inc = 1'b0; step();
      chk("coinc_no_strobe", cnt_h + cnt_m + cnt_s, 0);

      // SET_SEC timeout
      press_mode();
      chk("in_set_sec", mode_state, 1);
      for (int i = 0; i < TMO; i++) begin
         tick_1hz = 1'b1; step();
         tick_1hz = 1'b0;
         if (i != TMO - 1) step();
      end
      chk("pre_timeout_state", mode_state, 1);
      step();
      chk("timeout_state", mode_state, 0);
      chk("timeout_sel", select_mode, 0);
      chk("timeout_run", run_en, 1);

      // reset during auto-repeat
      press_mode();
      btn_inc = 1'b1; step();
      for (int i = 0; i < 3; i++) pulse_2hz();
      tick_2hz = 1'b1; rst_n = 1'b0; step();
      chk("rst_state", mode_state, 0);
      chk("rst_strobes", {inc_hour, inc_min, inc_sec}, 0);
      chk("rst_run", run_en, 1);
      tick_2hz = 1'b0; rst_n = 1'b1; step();
      btn_inc = 1'b0; step();

      // random traffic checked against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(0, 3) == 0) btn_inc = ~btn_inc;
         tick_1hz = ($urandom_range(0, 3) == 0);
         tick_2hz = ($urandom_range(0, 2) == 0);
         rst_n = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_n = 1'b1;
      chk("queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
